// File: rtl/mci_cif_multi_target_decode.sv
// Multi-target decoder between the axi_sub simplex component interface and
// NUM_TGT generic targets. It adds runtime address windows, per-target
// privilege gating, a registered request/response stage and a stall timeout.
module mci_cif_multi_target_decode #(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned UW             = 32,
    parameter int unsigned NUM_TGT        = 4,
    parameter int unsigned NUM_PRIV       = 3,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_dv,
    input  logic [AW-1:0]           s_addr,
    input  logic                    s_write,
    input  logic [UW-1:0]           s_user,
    input  logic [DW-1:0]           s_wdata,
    input  logic [DW/8-1:0]         s_wstrb,
    output logic                    s_hold,
    output logic [DW-1:0]           s_rdata,
    output logic                    s_error,
    output logic [NUM_TGT-1:0]      t_dv,
    output logic [AW-1:0]           t_addr,
    output logic                    t_write,
    output logic [DW-1:0]           t_wdata,
    output logic [DW/8-1:0]         t_wstrb,
    output logic [UW-1:0]           t_user,
    input  logic [NUM_TGT-1:0]      t_hold,
    input  logic [NUM_TGT*DW-1:0]   t_rdata,
    input  logic [NUM_TGT-1:0]      t_error,
    input  logic [NUM_TGT*AW-1:0]   tgt_base,
    input  logic [NUM_TGT*AW-1:0]   tgt_mask,
    input  logic [NUM_TGT-1:0]      tgt_priv_only,
    input  logic [NUM_PRIV*UW-1:0]  priv_user,
    input  logic [NUM_PRIV-1:0]     priv_user_en,
    output logic                    priv_req,
    output logic                    timeout_evt
);

    localparam int unsigned SW      = DW / 8;
    localparam int unsigned CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [NUM_TGT-1:0]   sel_q;
    logic [CW-1:0]        cnt;
    logic [NUM_TGT-1:0]   hit_oh;
    logic                 any_hit;
    logic                 priv_match;
    logic                 dec_err;
    logic                 hold_sel;
    logic                 err_sel;
    logic [DW-1:0]        rdata_sel;
    logic                 to_hit;

    // Window decode: first (lowest-index) matching window wins
    always_comb begin
        hit_oh  = '0;
        any_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_TGT; i++) begin
            if (!any_hit &&
                ((s_addr & ~tgt_mask[i*AW +: AW]) ==
                 (tgt_base[i*AW +: AW] & ~tgt_mask[i*AW +: AW]))) begin
                hit_oh[i] = 1'b1;
                any_hit   = 1'b1;
            end
        end
    end

    // Privilege match against enabled user straps
    always_comb begin
        priv_match = 1'b0;
        for (int unsigned j = 0; j < NUM_PRIV; j++) begin
            if (priv_user_en[j] && (priv_user[j*UW +: UW] == s_user)) begin
                priv_match = 1'b1;
            end
        end
    end

    assign dec_err = !any_hit || ((|(hit_oh & tgt_priv_only)) && !priv_match);

    // Selected target's response lines, muxed by the captured one-hot select
    always_comb begin
        rdata_sel = '0;
        for (int unsigned i = 0; i < NUM_TGT; i++) begin
            rdata_sel = rdata_sel | (t_rdata[i*DW +: DW] & {DW{sel_q[i]}});
        end
    end

    assign hold_sel = |(t_hold & sel_q);
    assign err_sel  = |(t_error & sel_q);
    assign to_hit   = TO_EN && hold_sel && (cnt == CW'(TO_LAST));
    assign s_hold   = s_dv && (state != RESP);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (s_dv) next_state = dec_err ? RESP : ISSUE;
            ISSUE:   if (!hold_sel || to_hit) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request capture, target strobe, response registers and stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_dv        <= '0;
            t_addr      <= '0;
            t_write     <= 1'b0;
            t_wdata     <= '0;
            t_wstrb     <= '0;
            t_user      <= '0;
            sel_q       <= '0;
            priv_req    <= 1'b0;
            s_rdata     <= '0;
            s_error     <= 1'b0;
            timeout_evt <= 1'b0;
            cnt         <= '0;
        end else begin
            timeout_evt <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_dv) begin
                        t_addr   <= s_addr;
                        t_write  <= s_write;
                        t_wdata  <= s_wdata;
                        t_wstrb  <= SW'(s_wstrb);
                        t_user   <= s_user;
                        sel_q    <= hit_oh;
                        priv_req <= priv_match;
                        if (dec_err) begin
                            s_rdata <= '0;
                            s_error <= 1'b1;
                        end else begin
                            t_dv <= hit_oh;
                        end
                    end
                end
                ISSUE: begin
                    if (!hold_sel) begin
                        t_dv    <= '0;
                        s_rdata <= t_write ? '0 : rdata_sel;
                        s_error <= err_sel;
                        cnt     <= '0;
                    end else if (to_hit) begin
                        t_dv        <= '0;
                        s_rdata     <= '0;
                        s_error     <= 1'b1;
                        timeout_evt <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mci_cif_multi_target_decode.sv
// Scoreboard bench for mci_cif_multi_target_decode: the driver queues the
// expected response per request, a monitor checks it at the handshake.
module tb_mci_cif_multi_target_decode;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned UW  = 32;
    localparam int unsigned NT  = 4;
    localparam int unsigned NP  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_dv = 1'b0;
    logic [AW-1:0]     s_addr = '0;
    logic              s_write = 1'b0;
    logic [UW-1:0]     s_user = '0;
    logic [DW-1:0]     s_wdata = '0;
    logic [DW/8-1:0]   s_wstrb = '0;
    logic              s_hold;
    logic [DW-1:0]     s_rdata;
    logic              s_error;
    logic [NT-1:0]     t_dv;
    logic [AW-1:0]     t_addr;
    logic              t_write;
    logic [DW-1:0]     t_wdata;
    logic [DW/8-1:0]   t_wstrb;
    logic [UW-1:0]     t_user;
    logic [NT-1:0]     t_hold;
    logic [NT*DW-1:0]  t_rdata;
    logic [NT-1:0]     t_error;
    logic [NT*AW-1:0]  tgt_base;
    logic [NT*AW-1:0]  tgt_mask;
    logic [NT-1:0]     tgt_priv_only;
    logic [NP*UW-1:0]  priv_user;
    logic [NP-1:0]     priv_user_en;
    logic              priv_req;
    logic              timeout_evt;

    logic [AW-1:0] base [NT];
    logic [AW-1:0] mask [NT];
    logic [DW-1:0] rd   [NT];
    logic [UW-1:0] pu   [NP];
    int            hold_n [NT];
    int            tcnt   [NT];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  tdv;
        int          tdv_cyc;
        int          lat;
        logic        priv;
        int          to_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int         m_lat = 0;
    int         m_tdv_cyc = 0;
    int         m_to = 0;
    logic [3:0] m_tdv_acc = '0;

    mci_cif_multi_target_decode #(
        .AW(AW), .DW(DW), .UW(UW), .NUM_TGT(NT), .NUM_PRIV(NP), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .s_dv(s_dv), .s_addr(s_addr), .s_write(s_write), .s_user(s_user),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_hold(s_hold),
        .s_rdata(s_rdata), .s_error(s_error),
        .t_dv(t_dv), .t_addr(t_addr), .t_write(t_write), .t_wdata(t_wdata),
        .t_wstrb(t_wstrb), .t_user(t_user), .t_hold(t_hold),
        .t_rdata(t_rdata), .t_error(t_error),
        .tgt_base(tgt_base), .tgt_mask(tgt_mask), .tgt_priv_only(tgt_priv_only),
        .priv_user(priv_user), .priv_user_en(priv_user_en),
        .priv_req(priv_req), .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    // Pack bench config arrays onto the flat config ports
    always_comb begin
        for (int i = 0; i < NT; i++) begin
            tgt_base[i*AW +: AW] = base[i];
            tgt_mask[i*AW +: AW] = mask[i];
            t_rdata[i*DW +: DW]  = rd[i];
        end
        for (int j = 0; j < NP; j++) priv_user[j*UW +: UW] = pu[j];
    end

    // Target model: hold for hold_n[i] cycles of t_dv, then respond
    always_comb begin
        for (int i = 0; i < NT; i++) t_hold[i] = t_dv[i] && (tcnt[i] < hold_n[i]);
    end

    always @(posedge clk) begin
        for (int i = 0; i < NT; i++) begin
            if (!t_dv[i]) tcnt[i] <= 0;
            else if (t_hold[i]) tcnt[i] <= tcnt[i] + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] rdata, input logic err, input logic [3:0] tdv,
                                input int cyc, input int lat, input logic priv, input int to);
        exp_t e;
        e.rdata = rdata; e.err = err; e.tdv = tdv; e.tdv_cyc = cyc;
        e.lat = lat; e.priv = priv; e.to_cnt = to;
        return e;
    endfunction

    // Monitor: accumulate per-transaction observations, compare at handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            m_lat = 0; m_tdv_cyc = 0; m_to = 0; m_tdv_acc = '0;
        end else begin
            if (s_dv) m_lat++;
            if (t_dv != '0) begin
                m_tdv_acc = m_tdv_acc | t_dv;
                m_tdv_cyc++;
            end
            if (timeout_evt) m_to++;
            if (s_dv && !s_hold) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_response", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("s_rdata", 64'(s_rdata), 64'(e.rdata));
                    check("s_error", 64'(s_error), 64'(e.err));
                    check("t_dv_pattern", 64'(m_tdv_acc), 64'(e.tdv));
                    check("t_dv_cycles", 64'(m_tdv_cyc), 64'(e.tdv_cyc));
                    check("latency", 64'(m_lat), 64'(e.lat));
                    check("priv_req", 64'(priv_req), 64'(e.priv));
                    check("timeout_evt_pulses", 64'(m_to), 64'(e.to_cnt));
                end
                m_lat = 0; m_tdv_cyc = 0; m_to = 0; m_tdv_acc = '0;
            end
        end
    end

    task automatic do_req(input logic [31:0] addr, input logic wr, input logic [31:0] user,
                          input logic [31:0] wdata, input logic [3:0] wstrb, input exp_t e);
        bit done = 1'b0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        s_addr = addr; s_write = wr; s_user = user; s_wdata = wdata; s_wstrb = wstrb;
        s_dv = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (s_dv && !s_hold) done = 1'b1;
        end
        if (!done) check("handshake_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        s_dv = 1'b0;
        check("t_addr", 64'(t_addr), 64'(addr));
        check("t_write", 64'(t_write), 64'(wr));
        check("t_wdata", 64'(t_wdata), 64'(wdata));
        check("t_wstrb", 64'(t_wstrb), 64'(wstrb));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        base[0] = 32'h0000_0000; mask[0] = 32'h0000_FFFF; rd[0] = 32'h0A0A_0A0A;
        base[1] = 32'h0010_0000; mask[1] = 32'h0000_FFFF; rd[1] = 32'hDEAD_BEEF;
        base[2] = 32'h0020_0000; mask[2] = 32'h0000_FFFF; rd[2] = 32'h2222_2222;
        base[3] = 32'h0000_0000; mask[3] = 32'h00FF_FFFF; rd[3] = 32'h3333_3333;
        pu[0] = 32'h11; pu[1] = 32'h22; pu[2] = 32'h33;
        priv_user_en = 3'b111;
        tgt_priv_only = 4'b0000;
        t_error = 4'b0000;
        for (int i = 0; i < NT; i++) hold_n[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_t_dv", 64'(t_dv), 64'd0);
        check("rst_s_rdata", 64'(s_rdata), 64'd0);
        check("rst_s_error", 64'(s_error), 64'd0);
        check("rst_priv_req", 64'(priv_req), 64'd0);
        check("rst_timeout_evt", 64'(timeout_evt), 64'd0);
        check("rst_t_addr", 64'(t_addr), 64'd0);
        rst = 1'b0;

        // Basic read of tgt1
        do_req(32'h0010_0040, 1'b0, 32'h0, 32'h0, 4'h0, mk(32'hDEAD_BEEF, 1'b0, 4'b0010, 1, 3, 1'b0, 0));
        // No window hit
        do_req(32'h0F00_0000, 1'b0, 32'h0, 32'h0, 4'h0, mk(32'h0, 1'b1, 4'b0000, 0, 2, 1'b0, 0));
        // Privileged-only target, unprivileged user
        tgt_priv_only = 4'b0100;
        do_req(32'h0020_0010, 1'b1, 32'h55, 32'hCAFE_F00D, 4'b0101, mk(32'h0, 1'b1, 4'b0000, 0, 2, 1'b0, 0));
        // Same with matching enabled strap: write, rdata forced 0
        pu[0] = 32'h55;
        do_req(32'h0020_0010, 1'b1, 32'h55, 32'hCAFE_F00D, 4'b0101, mk(32'h0, 1'b0, 4'b0100, 1, 3, 1'b1, 0));
        // tgt0 stalls forever: 8 cycles of t_dv, then timeout error
        hold_n[0] = 1000;
        do_req(32'h0000_0100, 1'b0, 32'h0, 32'h0, 4'h0, mk(32'h0, 1'b1, 4'b0001, 8, 10, 1'b0, 1));
        hold_n[0] = 0;
        do_req(32'h0010_0040, 1'b0, 32'h0, 32'h0, 4'h0, mk(32'hDEAD_BEEF, 1'b0, 4'b0010, 1, 3, 1'b0, 0));
        // Overlap tgt0/tgt3: lowest index wins; tgt3-only address
        do_req(32'h0000_1234, 1'b0, 32'h0, 32'h0, 4'h0, mk(32'h0A0A_0A0A, 1'b0, 4'b0001, 1, 3, 1'b0, 0));
        do_req(32'h0050_0000, 1'b0, 32'h0, 32'h0, 4'h0, mk(32'h3333_3333, 1'b0, 4'b1000, 1, 3, 1'b0, 0));
        // tgt2 holds 5 cycles: read with data, then write with target error
        hold_n[2] = 5;
        do_req(32'h0020_0004, 1'b0, 32'h55, 32'h0, 4'h0, mk(32'h2222_2222, 1'b0, 4'b0100, 6, 8, 1'b1, 0));
        t_error = 4'b0100;
        do_req(32'h0020_0000, 1'b1, 32'h55, 32'h1234_5678, 4'hF, mk(32'h0, 1'b1, 4'b0100, 6, 8, 1'b1, 0));
        t_error = 4'b0000;
        hold_n[2] = 0;

        // Reset while tgt0 is stalling: t_dv drops at once, no response
        hold_n[0] = 1000;
        @(posedge clk); #1;
        s_addr = 32'h0000_0100; s_write = 1'b0; s_user = 32'h0; s_dv = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t_dv_before_rst", 64'(t_dv), 64'd1);
        rst = 1'b1;
        #1;
        check("t_dv_async_rst", 64'(t_dv), 64'd0);
        @(posedge clk); #1;
        s_dv = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        hold_n[0] = 0;
        do_req(32'h0010_0040, 1'b0, 32'h0, 32'h0, 4'h0, mk(32'hDEAD_BEEF, 1'b0, 4'b0010, 1, 3, 1'b0, 0));

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
